// File: rtl/ucsbece154b_dmem_resp_pkg.sv
// Shared definitions for the M-stage data-memory responder: funct3 size
// codes, FSM state encodings and small decode helpers.
package ucsbece154b_dmem_resp_pkg;

  // funct3 access size/sign codes (load and store share the encoding)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Decoded access width
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmemState_t;

  // Map funct3 to an access width; reserved codes behave as a word access.
  function automatic logic [1:0] accessSize(input logic [2:0] funct3);
    logic [1:0] size;
    case (funct3)
      F3_B, F3_BU: size = SZ_BYTE;
      F3_H, F3_HU: size = SZ_HALF;
      default:     size = SZ_WORD;
    endcase
    return size;
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLow);
    logic mis;
    case (accessSize(funct3))
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addrLow[0];
      default: mis = (addrLow != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ucsbece154b_ldst_align.sv
// Combinational load/store alignment: byte-lane merge for stores,
// lane select plus sign/zero extension for loads, and the misalign check.
module ucsbece154b_ldst_align
  import ucsbece154b_dmem_resp_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLow,
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [1:0]  size_s;
  logic [31:0] shifted_s;
  logic        unsignedLd_s;

  // Decode width/sign and bring the addressed lane down to bit 0.
  always_comb begin
    size_s       = accessSize(funct3);
    shifted_s    = oldWord >> {addrLow, 3'b000};
    unsignedLd_s = funct3[2];
    misaligned   = isMisaligned(funct3, addrLow);
  end

  // Store merge: replace only the addressed lanes, keep the other bytes.
  always_comb begin
    mergedWord = oldWord;
    case (size_s)
      SZ_BYTE: begin
        case (addrLow)
          2'd0:    mergedWord[7:0]   = storeData[7:0];
          2'd1:    mergedWord[15:8]  = storeData[7:0];
          2'd2:    mergedWord[23:16] = storeData[7:0];
          2'd3:    mergedWord[31:24] = storeData[7:0];
          default: mergedWord        = oldWord;
        endcase
      end
      SZ_HALF: begin
        if (addrLow[1]) begin
          mergedWord[31:16] = storeData[15:0];
        end else begin
          mergedWord[15:0]  = storeData[15:0];
        end
      end
      SZ_WORD: mergedWord = storeData;
      default: mergedWord = storeData;
    endcase
  end

  // Load extension: funct3[2] selects zero extension (BU/HU).
  always_comb begin
    loadData = shifted_s;
    case (size_s)
      SZ_BYTE: begin
        if (unsignedLd_s) begin
          loadData = {24'h000000, shifted_s[7:0]};
        end else begin
          loadData = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (unsignedLd_s) begin
          loadData = {16'h0000, shifted_s[15:0]};
        end else begin
          loadData = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SZ_WORD: loadData = shifted_s;
      default: loadData = shifted_s;
    endcase
  end

endmodule

// File: rtl/ucsbece154b_dmem_resp.sv
// Multi-cycle data-memory responder for the M stage. Accepts one load or
// store, stalls the pipeline for LATENCY cycles, then presents load data
// on a registered output for the DONE cycle and holds it afterwards.
module ucsbece154b_dmem_resp
  import ucsbece154b_dmem_resp_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM_i,
  input  logic        MemWriteM_i,
  input  logic [2:0]  funct3M_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  output logic [31:0] ReadDataM_o,
  output logic        StallM_o,
  output logic        MisalignM_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  dmemState_t  state_r, nextState_s;
  logic [3:0]  count_r;
  logic [31:0] addr_r, data_r, readData_r;
  logic [2:0]  funct3_r;
  logic        write_r;

  logic        req_s, misaligned_s, accept_s, doAccess_s, inRange_s;
  logic [31:0] opAddr_s, opData_s, oldWord_s, mergedWord_s, loadData_s;
  logic [2:0]  opFunct3_s;
  logic        opWrite_s;
  logic [AW-1:0] wordIdx_s;

  logic [31:0] mem [MEM_WORDS];

  // In IDLE the live request drives the datapath (needed for LATENCY==1
  // and for the misalign check); afterwards the captured copy does.
  always_comb begin
    req_s = MemReadM_i | MemWriteM_i;
    if (state_r == ST_IDLE) begin
      opAddr_s   = ALUResultM_i;
      opData_s   = WriteDataM_i;
      opFunct3_s = funct3M_i;
      opWrite_s  = MemWriteM_i;
    end else begin
      opAddr_s   = addr_r;
      opData_s   = data_r;
      opFunct3_s = funct3_r;
      opWrite_s  = write_r;
    end
  end

  ucsbece154b_ldst_align u_align (
    .funct3     (opFunct3_s),
    .addrLow    (opAddr_s[1:0]),
    .oldWord    (oldWord_s),
    .storeData  (opData_s),
    .mergedWord (mergedWord_s),
    .loadData   (loadData_s),
    .misaligned (misaligned_s)
  );

  // Word lookup with range check; out-of-range reads see zero.
  always_comb begin
    wordIdx_s = opAddr_s[AW+1:2];
    inRange_s = ({2'b00, opAddr_s[31:2]} < 32'(MEM_WORDS));
    if (inRange_s) begin
      oldWord_s = mem[wordIdx_s];
    end else begin
      oldWord_s = 32'h00000000;
    end
  end

  // Accept/access strobes: the access edge is the last stalled cycle.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && req_s && !misaligned_s;
    if (LATENCY == 1) begin
      doAccess_s = accept_s;
    end else begin
      doAccess_s = (state_r == ST_BUSY) && (count_r == 4'd1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            nextState_s = ST_DONE;
          end else begin
            nextState_s = ST_BUSY;
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_r == 4'd1) begin
          nextState_s = ST_DONE;
        end else begin
          nextState_s = ST_BUSY;
        end
      end
      ST_DONE: nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // FSM outputs: stall covers the accept cycle and all BUSY cycles.
  always_comb begin
    case (state_r)
      ST_IDLE: begin
        StallM_o    = accept_s;
        MisalignM_o = req_s & misaligned_s;
      end
      ST_BUSY: begin
        StallM_o    = 1'b1;
        MisalignM_o = 1'b0;
      end
      ST_DONE: begin
        StallM_o    = 1'b0;
        MisalignM_o = 1'b0;
      end
      default: begin
        StallM_o    = 1'b0;
        MisalignM_o = 1'b0;
      end
    endcase
  end

  // Latency counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= 4'd0;
      addr_r   <= 32'h00000000;
      data_r   <= 32'h00000000;
      funct3_r <= 3'b000;
      write_r  <= 1'b0;
    end else if (accept_s) begin
      count_r  <= 4'(LATENCY - 1);
      addr_r   <= ALUResultM_i;
      data_r   <= WriteDataM_i;
      funct3_r <= funct3M_i;
      write_r  <= MemWriteM_i;
    end else if (state_r == ST_BUSY) begin
      count_r  <= count_r - 4'd1;
    end else begin
      count_r  <= 4'd0;
    end
  end

  // Load result register; stores (including read+write) leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_r <= 32'h00000000;
    end else if (doAccess_s && !opWrite_s) begin
      readData_r <= inRange_s ? loadData_s : 32'h00000000;
    end else begin
      readData_r <= readData_r;
    end
  end

  // Storage write port; not reset, and an out-of-range store is dropped.
  always_ff @(posedge clk) begin
    if (!reset && doAccess_s && opWrite_s && inRange_s) begin
      mem[wordIdx_s] <= mergedWord_s;
    end
  end

  assign ReadDataM_o = readData_r;

endmodule
